// File: rtl/stack_ctrl.sv
// Multicycle control FSM for the stack processor: instruction sequencing, stack-depth tracking.
// Build option STK_GUARD_EN: trap stack under/overflow in DEC and park in ERR.
module stack_ctrl #(
   parameter int DEPTH = 32,
   parameter int DW_D  = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      opcode,
   input  logic            zero,
   output logic            ir_ld,
   output logic            pc_ld,
   output logic            pc_src,
   output logic            adr_src,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            stk_push,
   output logic            stk_pop,
   output logic            stk_tos,
   output logic            stk_src,
   output logic            a_ld,
   output logic            b_ld,
   output logic [1:0]      alu_op,
   output logic            busy,
   output logic            retire,
   output logic            err,
   output logic [DW_D-1:0] depth
);

   typedef enum logic [4:0] {
      S_IDLE, S_FETCH, S_DEC, S_BP1, S_BP2, S_BLB, S_UP1, S_ULA, S_EXE,
      S_PR, S_PW, S_OP1, S_OW, S_J1, S_JZ1, S_JZ2, S_ERR
   } state_t;

   typedef struct packed {
      logic       ir_ld;
      logic       pc_ld;
      logic       pc_src;
      logic       adr_src;
      logic       mem_rd;
      logic       mem_wr;
      logic       stk_push;
      logic       stk_pop;
      logic       stk_tos;
      logic       stk_src;
      logic       a_ld;
      logic       b_ld;
      logic [1:0] alu_op;
      logic       busy;
      logic       retire;
      logic       err;
   } ctl_t;

   if (DW_D < $clog2(DEPTH) + 1) begin : g_dw_check
      $error("stack_ctrl: DW_D too narrow for DEPTH");
   end

   state_t          state_reg;
   state_t          state_next;
   ctl_t            ctl_reg;
   logic [DW_D-1:0] depth_reg;
   logic            guard_ok;

   // Control word for a state; registered on entry so outputs are glitch-free.
   function automatic ctl_t decode(input state_t s, input logic [1:0] alu_sel);
      ctl_t c;
      c      = '0;
      c.busy = (s != S_IDLE) && (s != S_ERR);
      case (s)
         S_FETCH: begin c.mem_rd = 1'b1; c.ir_ld = 1'b1; c.pc_ld = 1'b1; end
         S_BP1:   c.stk_pop = 1'b1;
         S_BP2:   begin c.stk_pop = 1'b1; c.a_ld = 1'b1; end
         S_BLB:   c.b_ld = 1'b1;
         S_UP1:   c.stk_pop = 1'b1;
         S_ULA:   c.a_ld = 1'b1;
         S_EXE:   begin c.alu_op = alu_sel; c.stk_src = 1'b1; c.stk_push = 1'b1; c.retire = 1'b1; end
         S_PR:    begin c.mem_rd = 1'b1; c.adr_src = 1'b1; end
         S_PW:    begin c.stk_push = 1'b1; c.retire = 1'b1; end
         S_OP1:   c.stk_pop = 1'b1;
         S_OW:    begin c.mem_wr = 1'b1; c.adr_src = 1'b1; c.retire = 1'b1; end
         S_J1:    begin c.pc_ld = 1'b1; c.pc_src = 1'b1; c.retire = 1'b1; end
         S_JZ1:   c.stk_tos = 1'b1;
         S_JZ2:   begin c.pc_src = 1'b1; c.retire = 1'b1; end
         S_ERR:   c.err = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

`ifdef STK_GUARD_EN
   localparam logic [DW_D-1:0] DEPTH_FULL = DW_D'(DEPTH);
   always_comb begin
      guard_ok = 1'b1;
      case (opcode)
         3'b000, 3'b001, 3'b010: guard_ok = (depth_reg >= DW_D'(2));
         3'b011, 3'b101, 3'b111: guard_ok = (depth_reg >= DW_D'(1));
         3'b100:                 guard_ok = (depth_reg < DEPTH_FULL);
         default:                guard_ok = 1'b1;
      endcase
   end
`else
   assign guard_ok = 1'b1;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start) state_next = S_FETCH;
         S_FETCH: state_next = S_DEC;
         S_DEC: begin
            if (!guard_ok) begin
               state_next = S_ERR;
            end else begin
               case (opcode)
                  3'b011:  state_next = S_UP1;
                  3'b100:  state_next = S_PR;
                  3'b101:  state_next = S_OP1;
                  3'b110:  state_next = S_J1;
                  3'b111:  state_next = S_JZ1;
                  default: state_next = S_BP1;
               endcase
            end
         end
         S_BP1:   state_next = S_BP2;
         S_BP2:   state_next = S_BLB;
         S_BLB:   state_next = S_EXE;
         S_UP1:   state_next = S_ULA;
         S_ULA:   state_next = S_EXE;
         S_PR:    state_next = S_PW;
         S_OP1:   state_next = S_OW;
         S_JZ1:   state_next = S_JZ2;
         S_EXE, S_PW, S_OW, S_J1, S_JZ2: state_next = S_FETCH;
         S_ERR:   state_next = S_ERR;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         ctl_reg   <= '0;
         depth_reg <= '0;
      end else begin
         state_reg <= state_next;
         ctl_reg   <= decode(state_next, opcode[1:0]);
         // Depth follows the strobes actually issued this cycle; wraps like the stack pointer.
         if (ctl_reg.stk_push)
            depth_reg <= depth_reg + DW_D'(1);
         else if (ctl_reg.stk_pop)
            depth_reg <= depth_reg - DW_D'(1);
      end
   end

   assign ir_ld    = ctl_reg.ir_ld;
   assign pc_ld    = ctl_reg.pc_ld | ((state_reg == S_JZ2) & zero);
   assign pc_src   = ctl_reg.pc_src;
   assign adr_src  = ctl_reg.adr_src;
   assign mem_rd   = ctl_reg.mem_rd;
   assign mem_wr   = ctl_reg.mem_wr;
   assign stk_push = ctl_reg.stk_push;
   assign stk_pop  = ctl_reg.stk_pop;
   assign stk_tos  = ctl_reg.stk_tos;
   assign stk_src  = ctl_reg.stk_src;
   assign a_ld     = ctl_reg.a_ld;
   assign b_ld     = ctl_reg.b_ld;
   assign alu_op   = ctl_reg.alu_op;
   assign busy     = ctl_reg.busy;
   assign retire   = ctl_reg.retire;
   assign err      = ctl_reg.err;
   assign depth    = depth_reg;

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Multicycle control FSM for the stack-based processor.
- Sequences the 32-entry stack (push/pop/tos), instruction memory, PC, IR, A/B operand registers and ALU.
- Decodes a 3-bit opcode.
- Tracks stack depth so illegal pops or pushes are trapped before they corrupt the stack pointer.

Parameters:
- DEPTH, 32, number of stack entries; must match the stack datapath.
- DW_D, 6, width of the depth counter; must be at least clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching from the current PC.
- opcode  in  3  IR[7:5]. 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
- zero  in  1  datapath flag: stack output equals 0.
- ir_ld  out  1  load IR from memory data.
- pc_ld  out  1  load PC.
- pc_src  out  1  0 = PC+1, 1 = IR address field.
- adr_src  out  1  memory address select: 0 = PC, 1 = IR address field.
- mem_rd  out  1  memory read.
- mem_wr  out  1  memory write; data comes from the stack output.
- stk_push  out  1  stack push.
- stk_pop  out  1  stack pop.
- stk_tos  out  1  stack top-of-stack read.
- stk_src  out  1  stack data-in select: 0 = memory data, 1 = ALU result.
- a_ld  out  1  load A from the stack output.
- b_ld  out  1  load B from the stack output.
- alu_op  out  2  00 add, 01 sub (A-B), 10 and, 11 not A.
- busy  out  1  high in every state except IDLE and ERR.
- retire  out  1  one-cycle pulse in the final state of each instruction.
- err  out  1  sticky stack-fault flag.
- depth  out  DW_D  current stack occupancy.

Behaviour:
- Reset:
  - state = IDLE, depth = 0, err = 0.
  - All outputs are 0.
  - Reset applies immediately, mid-instruction included; no partial instruction resumes.
- All control outputs are Moore, decoded from state only. The one exception is pc_ld in JZ2, which also depends on zero.
- Stack timing: stack data is valid on its output the cycle after stk_pop/stk_tos, and a_ld/b_ld are issued in that cycle. Memory read data is likewise valid the cycle after mem_rd.
- IDLE: wait; start=1 -> FETCH.
- FETCH: mem_rd=1, adr_src=0, ir_ld=1, pc_ld=1, pc_src=0 -> DEC.
- DEC: guard check (Optional Feature), then branch on opcode.
- ADD/SUB/AND: BP1 (stk_pop) -> BP2 (stk_pop, a_ld) -> BLB (b_ld) -> EXE.
- NOT: UP1 (stk_pop) -> ULA (a_ld) -> EXE.
- EXE: alu_op from opcode, stk_src=1, stk_push=1, retire=1 -> FETCH.
- PUSH: PR (mem_rd, adr_src=1) -> PW (stk_push, stk_src=0, retire) -> FETCH.
- POP: OP1 (stk_pop) -> OW (mem_wr, adr_src=1, retire) -> FETCH.
- JMP: J1 (pc_ld, pc_src=1, retire) -> FETCH.
- JZ: JZ1 (stk_tos) -> JZ2 (pc_ld = zero, pc_src=1, retire) -> FETCH. JZ does not pop.
- ERR: err=1, all strobes 0. Exit only by reset.
- Depth counter:
  - +1 on every cycle with stk_push.
  - -1 on every cycle with stk_pop.
  - Never both in the same cycle.
  - Net instruction effect: binary -1, NOT 0, PUSH +1, POP -1.
- Instruction cycle counts, FETCH to retire inclusive: binary 6, NOT 5, PUSH 4, POP 4, JMP 3, JZ 4.
- start is ignored outside IDLE.

Optional Feature:
- Macro: STK_GUARD_EN.
- Defined: DEC checks depth before dispatch.
  - Binary ops require depth >= 2.
  - NOT, POP and JZ require depth >= 1.
  - PUSH requires depth < DEPTH.
  - On violation: -> ERR. No stack strobe is issued and PC is not reloaded further.
- Undefined: no checks and ERR is unreachable (err stays 0); depth wraps modulo 2^DW_D, matching the stack pointer wrapping in the datapath.

Test Plan:
- Reset then start, PUSH 5, PUSH 3, SUB -> strobe order matches the spec; EXE has alu_op=01; depth goes 1, 2, 1; three retire pulses; totals 4+4+6 cycles.
- PUSH 0, JZ to address 0x0A -> JZ2 has zero=1 and pc_ld=1 with pc_src=1; depth stays 1. Repeat with zero=0 -> pc_ld=0 in JZ2.
- With STK_GUARD_EN, ADD at depth 1 -> ERR entered from DEC; err=1, busy=0; no stk_pop ever asserted; depth stays 1.
- With STK_GUARD_EN, 32 PUSHes then a 33rd PUSH -> depth=32, then ERR; stk_push is not asserted for the 33rd.
- Without STK_GUARD_EN, POP at depth 0 -> completes in 4 cycles, depth wraps to 63, err=0.
- Assert rst_n=0 in BP2 -> all outputs 0 asynchronously; state IDLE, depth 0. After release, start re-fetches from the current PC.
